cic_decim_mc: RTL and testbench

// - Multi-channel CIC decimator for the DUC/DDC RFNoC chains; one instance serves NUM_CHANS parallel complex lanes.
// - Sits between axi_rate_change and the chain output. Replaces fixed-ratio decimation with a runtime power-of-two ratio set from the settings bus.
// - Carries exact CIC gain compensation, tlast propagation and readback.

---
 rtl/cic_decim_mc.sv | 175 +++++++++++++++++
 tb/tb_cic_decim_mc.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// Multi-lane CIC decimator with a runtime power-of-two ratio, exact gain compensation and tlast carry.
// Output is one cycle after the R-th accepted input; one-deep output register, i_tready = !o_tvalid | o_tready.
module cic_decim_mc #(
  parameter int          NUM_CHANS      = 1,
  parameter int          SAMP_WIDTH     = 16,
  parameter int          NUM_STAGES     = 4,
  parameter int          LOG2_MAX_DECIM = 5,
  parameter logic [7:0]  SR_DECIM_ADDR  = 8'd160,
  parameter logic [63:0] COMPAT_NUM     = 64'h1_0
) (
  input  logic                              ce_clk,
  input  logic                              ce_rst_n,
  input  logic                              clear,
  input  logic                              set_stb,
  input  logic [7:0]                        set_addr,
  input  logic [31:0]                       set_data,
  input  logic [7:0]                        rb_addr,
  output logic [63:0]                       rb_data,
  input  logic [NUM_CHANS*2*SAMP_WIDTH-1:0] i_tdata,
  input  logic                              i_tlast,
  input  logic                              i_tvalid,
  output logic                              i_tready,
  output logic [NUM_CHANS*2*SAMP_WIDTH-1:0] o_tdata,
  output logic                              o_tlast,
  output logic                              o_tvalid,
  input  logic                              o_tready
);

  localparam int NCOMP = 2 * NUM_CHANS;
  localparam int DW    = NCOMP * SAMP_WIDTH;
  localparam int ACC_W = SAMP_WIDTH + NUM_STAGES * LOG2_MAX_DECIM;
  localparam int LW    = $clog2(LOG2_MAX_DECIM + 1);
  localparam int SH_W  = $clog2(NUM_STAGES * LOG2_MAX_DECIM + 1);
  localparam int PH_W  = (LOG2_MAX_DECIM > 0) ? LOG2_MAX_DECIM : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (SAMP_WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [LW-1:0]   dec_l;
  logic [LW-1:0]   l_new;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_max;
  logic [SH_W-1:0] shamt;
  logic            tl_flag;
  logic [31:0]     out_cnt;
  logic [DW-1:0]   out_nxt;
  logic            rate_wr;
  logic            accept;
  logic            upd;
  logic            last_in;
  logic            load;
  logic            st_clr;
  logic            unused_set;

  assign unused_set = ^set_data[31:8];

  assign rate_wr   = set_stb && (set_addr == SR_DECIM_ADDR);
  assign l_new     = (set_data[7:0] > 8'(LOG2_MAX_DECIM)) ? LW'(LOG2_MAX_DECIM) : set_data[LW-1:0];
  assign i_tready  = !clear && (!o_tvalid || o_tready);
  assign accept    = i_tvalid && i_tready;
  // A rate write in the same cycle wins: the accepted sample never reaches the filter.
  assign upd       = accept && !rate_wr;
  assign phase_max = PH_W'((1 << dec_l) - 1);
  assign last_in   = (phase == phase_max);
  assign load      = upd && last_in;
  assign st_clr    = clear || rate_wr;
  assign shamt     = SH_W'(NUM_STAGES * dec_l);

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      dec_l    <= '0;
      phase    <= '0;
      tl_flag  <= 1'b0;
      out_cnt  <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else begin
      if (rate_wr) dec_l <= l_new;

      if (clear) begin
        o_tvalid <= 1'b0;
        o_tlast  <= 1'b0;
        out_cnt  <= '0;
      end else begin
        if (o_tvalid && o_tready) out_cnt <= out_cnt + 32'd1;
        if (load) begin
          o_tvalid <= 1'b1;
          o_tdata  <= out_nxt;
          o_tlast  <= tl_flag | i_tlast;
        end else if (o_tready) begin
          o_tvalid <= 1'b0;
        end
      end

      if (st_clr) begin
        phase   <= '0;
        tl_flag <= 1'b0;
      end else if (upd) begin
        if (last_in) begin
          phase   <= '0;
          tl_flag <= 1'b0;
        end else begin
          phase   <= phase + PH_W'(1);
          tl_flag <= tl_flag | i_tlast;
        end
      end
    end
  end

  for (genvar c = 0; c < NCOMP; c++) begin : g_comp
    logic [ACC_W-1:0]        samp_ext;
    logic [ACC_W-1:0]        comb_out;
    logic [ACC_W-1:0]        rnd;
    logic [ACC_W-1:0]        biased;
    logic signed [ACC_W-1:0] scaled;
    logic [SAMP_WIDTH-1:0]   sat;

    assign samp_ext = {{(ACC_W-SAMP_WIDTH){i_tdata[c*SAMP_WIDTH+SAMP_WIDTH-1]}},
                       i_tdata[c*SAMP_WIDTH +: SAMP_WIDTH]};

    // Integrators cascade combinationally so the comb sees this sample's fully updated sum.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_int
      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] nxt;
      if (k == 0) begin : g_first
        assign nxt = acc + samp_ext;
      end else begin : g_chain
        assign nxt = acc + g_int[k-1].nxt;
      end
      always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n)   acc <= '0;
        else if (st_clr) acc <= '0;
        else if (upd)    acc <= nxt;
      end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_comb
      logic [ACC_W-1:0] dly;
      logic [ACC_W-1:0] din;
      logic [ACC_W-1:0] dout;
      if (k == 0) begin : g_first
        assign din = g_int[NUM_STAGES-1].nxt;
      end else begin : g_chain
        assign din = g_comb[k-1].dout;
      end
      assign dout = din - dly;
      always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n)   dly <= '0;
        else if (st_clr) dly <= '0;
        else if (load)   dly <= din;
      end
    end

    // Gain is exactly 2^(N*L); round half up before the arithmetic shift, then clamp.
    assign comb_out = g_comb[NUM_STAGES-1].dout;
    assign rnd      = (shamt == '0) ? '0 : (ACC_W'(1) << (shamt - SH_W'(1)));
    assign biased   = comb_out + rnd;
    assign scaled   = $signed(biased) >>> shamt;
    assign sat      = (scaled > SAT_MAX) ? SAT_MAX[SAMP_WIDTH-1:0] :
                      (scaled < SAT_MIN) ? SAT_MIN[SAMP_WIDTH-1:0] :
                      scaled[SAMP_WIDTH-1:0];
    assign out_nxt[c*SAMP_WIDTH +: SAMP_WIDTH] = sat;
  end

  always_comb begin
    case (rb_addr)
      8'd0:    rb_data = COMPAT_NUM;
      8'd1:    rb_data = {{(64-LW){1'b0}}, dec_l};
      8'd2:    rb_data = {32'd0, out_cnt};
      default: rb_data = 64'h0BAD_C0DE_0BAD_C0DE;
    endcase
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: convolution reference model (CIC kernel as a polynomial) checked every cycle,
// plus literal expectations for pass-through, DC gain, impulse rounding, tlast, stall, clear and reset.
module tb_cic_decim_mc;
  localparam int SW  = 16;
  localparam int NST = 4;
  localparam int DW  = 32;

  logic          ce_clk, ce_rst_n, clear, set_stb;
  logic [7:0]    set_addr, rb_addr;
  logic [31:0]   set_data;
  logic [63:0]   rb_data;
  logic [DW-1:0] i_tdata, o_tdata;
  logic          i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int            m_l;
  int            m_cnt;
  bit            m_tl, m_vld, m_last;
  logic [DW-1:0] m_dat;
  logic [31:0]   m_count;
  logic [DW-1:0] hist_q[$];
  longint        kern[0:127];
  int            kern_len;

  logic [DW-1:0] got_q[$];
  bit            got_last[$];
  logic [DW-1:0] held;

  cic_decim_mc dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_addr(rb_addr), .rb_data(rb_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  initial begin
    ce_clk = 1'b0;
    forever #5 ce_clk = ~ce_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pack(input int i, input int q);
    logic [31:0] r;
    r = {i[15:0], q[15:0]};
    return r;
  endfunction

  // Impulse response of N cascaded length-r moving sums: (1 + z + ... + z^(r-1))^N.
  task automatic build_kern(input int r);
    longint a[0:127];
    longint b[0:127];
    for (int i = 0; i < 128; i++) a[i] = (i == 0) ? 1 : 0;
    for (int s = 0; s < NST; s++) begin
      for (int i = 0; i < 128; i++) begin
        b[i] = 0;
        for (int d = 0; d < r; d++) if (i >= d) b[i] += a[i-d];
      end
      a = b;
    end
    for (int i = 0; i < 128; i++) kern[i] = a[i];
    kern_len = NST * (r - 1) + 1;
  endtask

  function automatic logic [DW-1:0] model_out();
    logic [DW-1:0] r;
    logic [SW-1:0] v;
    longint        s;
    int            sh, hn;
    r  = '0;
    sh = NST * m_l;
    hn = hist_q.size();
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int j = 0; j < kern_len && j < hn; j++) begin
        v = hist_q[hn-1-j][c*SW +: SW];
        s += kern[j] * longint'($signed(v));
      end
      if (sh > 0) s = s + (longint'(1) << (sh - 1));
      s = s >>> sh;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[c*SW +: SW] = s[SW-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_l = 0; m_cnt = 0; m_tl = 0; m_vld = 0; m_last = 0; m_dat = '0; m_count = '0;
    hist_q.delete();
    build_kern(1);
  endtask

  task automatic model_step();
    bit rdy, acc, rate, ohs;
    rdy  = !clear && (!m_vld || o_tready);
    acc  = i_tvalid && rdy;
    rate = set_stb && (set_addr == 8'd160);
    ohs  = m_vld && o_tready;
    if (rate) begin
      m_l = (set_data[7:0] > 5) ? 5 : int'(set_data[7:0]);
      build_kern(1 << m_l);
    end
    if (clear) begin
      hist_q.delete();
      m_cnt = 0; m_tl = 0; m_vld = 0; m_last = 0; m_count = '0;
    end else begin
      if (ohs) begin
        m_count = m_count + 32'd1;
        m_vld   = 0;
      end
      if (rate) begin
        hist_q.delete();
        m_cnt = 0; m_tl = 0;
      end else if (acc) begin
        hist_q.push_back(i_tdata);
        if (hist_q.size() > 140) void'(hist_q.pop_front());
        m_cnt++;
        m_tl = m_tl | i_tlast;
        if (m_cnt == (1 << m_l)) begin
          m_dat  = model_out();
          m_vld  = 1;
          m_last = m_tl;
          m_cnt  = 0;
          m_tl   = 0;
        end
      end
    end
  endtask

  // Compare process: DUT state after each posedge versus the model, every cycle.
  always @(negedge ce_clk) begin
    logic [63:0] exp_rb;
    if (!ce_rst_n) begin
      model_reset();
      check("rst_o_tdata", o_tdata, 64'd0);
    end
    case (rb_addr)
      8'd0:    exp_rb = 64'h10;
      8'd1:    exp_rb = 64'(m_l);
      8'd2:    exp_rb = {32'd0, m_count};
      default: exp_rb = 64'h0BADC0DE0BADC0DE;
    endcase
    check("o_tvalid", o_tvalid, m_vld);
    if (m_vld) begin
      check("o_tdata", o_tdata, m_dat);
      check("o_tlast", o_tlast, m_last);
    end
    check("i_tready", i_tready, !clear && (!m_vld || o_tready));
    check("rb_data", rb_data, exp_rb);
    if (ce_rst_n) model_step();
  end

  always @(negedge ce_clk) begin
    if (ce_rst_n && o_tvalid && o_tready) begin
      got_q.push_back(o_tdata);
      got_last.push_back(o_tlast);
    end
  end

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l);
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = l;
    tick();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic set_rate(input int v);
    set_stb  = 1'b1;
    set_addr = 8'd160;
    set_data = 32'(v);
    i_tvalid = 1'b0;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic got_clear();
    got_q.delete();
    got_last.delete();
  endtask

  task automatic rand_run(input int n, input int vpct, input int rpct, input int spct);
    for (int i = 0; i < n; i++) begin
      i_tvalid = ($urandom_range(0, 99) < vpct);
      i_tdata  = DW'($urandom);
      i_tlast  = ($urandom_range(0, 9) == 0);
      o_tready = ($urandom_range(0, 99) < rpct);
      rb_addr  = 8'($urandom_range(0, 4));
      set_stb  = ($urandom_range(0, 99) < spct);
      set_addr = ($urandom_range(0, 3) == 0) ? 8'd7 : 8'd160;
      set_data = 32'($urandom_range(0, 7));
      tick();
    end
    i_tvalid = 1'b0; i_tlast = 1'b0; set_stb = 1'b0; o_tready = 1'b1; rb_addr = 8'd2;
  endtask

  initial begin
    int k_sum;
    ce_rst_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    rb_addr = 8'd0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;

    // Pin the reference kernel against hand-expanded polynomials.
    build_kern(4);
    k_sum = 0;
    for (int i = 0; i < kern_len; i++) k_sum += int'(kern[i]);
    check("kern4_len", 64'(kern_len), 64'd13);
    check("kern4_c3", kern[3], 64'd20);
    check("kern4_c6", kern[6], 64'd44);
    check("kern4_sum", 64'(k_sum), 64'd256);
    build_kern(2);
    check("kern2_c2", kern[2], 64'd6);

    repeat (3) @(posedge ce_clk);
    #1 ce_rst_n = 1'b1;
    #1 check("rb_compat", rb_data, 64'h10);
    rb_addr = 8'd7;
    #1 check("rb_unmapped", rb_data, 64'h0BADC0DE0BADC0DE);
    rb_addr = 8'd2;

    // L=0: bit-exact pass-through, one cycle later, one per cycle.
    got_clear();
    send(pack(1234, -77), 1'b0);
    check("l0_latency", o_tvalid, 1'b1);
    repeat (4) send(pack(1234, -77), 1'b0);
    tick();
    check("l0_count", 64'(got_q.size()), 64'd5);
    check("l0_first", got_q[0], pack(1234, -77));
    check("l0_last", got_q[4], pack(1234, -77));

    // L=2 DC: gain compensated exactly once the kernel is filled.
    set_rate(2);
    got_clear();
    repeat (40) send(pack(1000, -1000), 1'b0);
    repeat (3) tick();
    check("dc_count", 64'(got_q.size()), 64'd10);
    check("dc_out4", got_q[4], pack(1000, -1000));
    check("dc_out9", got_q[9], pack(1000, -1000));

    // L=2 impulse: taps 20, 40, 4 of the kernel, >>8 with round half up.
    set_rate(2);
    got_clear();
    send(pack(16384, -100), 1'b0);
    repeat (15) send(pack(0, 0), 1'b0);
    repeat (3) tick();
    check("imp_0", got_q[0], pack(1280, -8));
    check("imp_1", got_q[1], pack(2560, -16));
    check("imp_2", got_q[2], pack(256, -2));
    check("imp_3", got_q[3], pack(0, 0));

    // L=2 tlast on the 6th input lands on the 2nd output only.
    set_rate(2);
    got_clear();
    for (int i = 0; i < 8; i++) send(pack(i, -i), (i == 5));
    repeat (3) tick();
    check("tl_count", 64'(got_last.size()), 64'd2);
    check("tl_out0", 64'(got_last[0]), 64'd0);
    check("tl_out1", 64'(got_last[1]), 64'd1);

    // L=3 with a 20-cycle output stall.
    set_rate(3);
    rand_run(30, 90, 100, 0);
    o_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_tvalid = 1'b1;
      i_tdata  = DW'($urandom);
      if (i == 10) held = o_tdata;
      tick();
    end
    check("stall_rdy", i_tready, 1'b0);
    check("stall_hold", o_tdata, held);
    o_tready = 1'b1;
    rand_run(60, 90, 100, 0);

    // Oversized rate saturates to the maximum.
    set_rate(9);
    rb_addr = 8'd1;
    #1 check("rb_l_clamp", rb_data, 64'd5);
    rand_run(400, 80, 70, 0);
    rand_run(600, 80, 75, 3);

    // Clear mid-group: input refused, count zeroed, fresh group needed.
    set_rate(2);
    send(pack(500, 500), 1'b0);
    send(pack(500, 500), 1'b0);
    clear = 1'b1;
    i_tvalid = 1'b1;
    i_tdata = pack(500, 500);
    #1 check("clr_rdy", i_tready, 1'b0);
    tick();
    clear = 1'b0;
    i_tvalid = 1'b0;
    rb_addr = 8'd2;
    #1 check("clr_count", rb_data, 64'd0);
    got_clear();
    repeat (3) send(pack(1000, 1000), 1'b0);
    tick();
    check("clr_nogroup", 64'(got_q.size()), 64'd0);
    send(pack(1000, 1000), 1'b0);
    tick();
    check("clr_fresh", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("clr_val", got_q[0], pack(137, 137));

    // Reset while an output is pending.
    set_rate(1);
    o_tready = 1'b0;
    send(pack(7, 7), 1'b0);
    send(pack(9, 9), 1'b0);
    check("rst_pending", o_tvalid, 1'b1);
    #2 ce_rst_n = 1'b0;
    #1 check("rst_vld", o_tvalid, 1'b0);
    rb_addr = 8'd2;
    #1 check("rst_cnt", rb_data, 64'd0);
    rb_addr = 8'd1;
    #1 check("rst_l", rb_data, 64'd0);
    @(posedge ce_clk);
    @(posedge ce_clk);
    #1 ce_rst_n = 1'b1;
    o_tready = 1'b1;
    rand_run(300, 85, 80, 2);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
